bs_worker_port: RTL and testbench
=================================

BS_WORKER_PORT -- requirements
Module: bs_worker_port

Interface
REQ-001 Parameter DATA_W, default 32, width of one option record word loaded into the worker.
REQ-002 Parameter RES_W, default 32, width of one pricing result.
REQ-003 Parameter CNT_W, default 16, width of the completed-job counter.
REQ-004 Ports SHALL be:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  feed has a record.
- in_data  in  DATA_W  record.
- in_ready  out  1  input buffer empty.
- BS_START  in  1  controller start request.
- SERVE_REG  in  1  controller grants output of the result.
- BS_READY  out  1  record buffered and core free.
- BS_DONE  out  1  result held, not yet served.
- BS_IDLE  out  1  no job in flight and no result held.
- hasUnusedData  out  1  input buffer holds an unconsumed record.
- core_start  out  1  one-cycle launch pulse to the pricing core.
- core_data  out  DATA_W  record presented with core_start.
- core_done  in  1  one-cycle completion pulse from the core.
- core_result  in  RES_W  result, valid with core_done.
- out_valid  out  1  result on out_data.
- out_data  out  RES_W  held result.
- out_ready  in  1  sink accepts the result.
- job_count  out  CNT_W  completed (served) jobs.
- proto_err  out  1  sticky protocol-violation flag.

Function
REQ-005 All outputs SHALL be registered; no input-to-output combinational path.
REQ-006 Job FSM states SHALL be IDLE, COMPUTE, DONE and SERVE; the input buffer is a separate one-entry register with a full flag.
REQ-007 The input buffer SHALL load in_data when in_valid and in_ready; in_ready SHALL equal !full, registered, with no same-cycle refill bypass.
REQ-008 hasUnusedData SHALL equal the buffer full flag.
REQ-009 BS_READY SHALL be 1 iff state==IDLE and full.
REQ-010 BS_IDLE SHALL be 1 iff state==IDLE, independent of the buffer.
REQ-011 BS_START sampled while BS_READY at cycle t: at t+1 core_start=1 for exactly one cycle, core_data=buffered record, full=0, state=COMPUTE, BS_READY=0, BS_IDLE=0.
REQ-012 BS_START while not BS_READY SHALL be ignored and set proto_err.
REQ-013 The buffer SHALL accept a new record during COMPUTE, DONE and SERVE, so that hasUnusedData=1 and BS_READY=0 until return to IDLE.
REQ-014 core_done in COMPUTE at cycle t: at t+1 out_data holds core_result, state=DONE, BS_DONE=1.
REQ-015 core_done outside COMPUTE SHALL be ignored and set proto_err; out_data SHALL NOT change.
REQ-016 SERVE_REG in DONE at cycle t: at t+1 state=SERVE and out_valid=1; BS_DONE stays 1 until the result is accepted.
REQ-017 SERVE_REG in any state other than DONE SHALL have no effect and SHALL NOT set proto_err.
REQ-018 In SERVE, out_valid and out_data SHALL hold stable until out_valid&&out_ready.
REQ-019 When out_valid&&out_ready at cycle t, at t+1:
- out_valid=0, BS_DONE=0;
- state=IDLE, BS_IDLE=1;
- job_count incremented by 1 modulo 2^CNT_W, wrapping from all-ones to 0.
REQ-020 If the buffer is full at that return to IDLE, BS_READY SHALL be 1 at t+1.
REQ-021 proto_err SHALL clear only on reset.

Reset
REQ-022 While reset=0, outputs SHALL immediately take these values:
- BS_IDLE=1, in_ready=1;
- all other outputs 0, including out_data, core_data and job_count;
- state=IDLE, full=0.
REQ-023 Reset asserted mid-job SHALL discard the buffered record and any held result, with no pulse emitted on release; the pricing core shares the same reset.
REQ-024 The first edge after reset deassertion SHALL already honour in_valid.

Verification
REQ-025 Basic job (bench):
- in_data=0x0000_1234 accepted -> hasUnusedData=1, BS_READY=1 next cycle;
- BS_START -> core_start pulse with core_data=0x1234;
- core_done with core_result=0xCAFE_0001 -> BS_DONE=1;
- SERVE_REG, then out_ready -> out_data=0xCAFE_0001, job_count=1, BS_IDLE=1.
REQ-026 Overlap (bench): a second record loaded during COMPUTE -> hasUnusedData=1 and BS_READY=0 until serve completes, then BS_READY=1 on the cycle after the handshake.
REQ-027 Protocol errors (bench): BS_START with the buffer empty -> no core_start, proto_err=1; a stray core_done in IDLE -> proto_err stays 1 and out_data is unchanged.
REQ-028 Backpressure (bench): out_ready=0 for 5 cycles in SERVE -> out_valid and out_data stable for all 5, BS_DONE=1, job_count unchanged.
REQ-029 Counter wrap (bench): preload via 65535 jobs (CNT_W=16), then one more -> job_count=0.
REQ-030 Reset mid-job (bench): reset=0 while in COMPUTE with the buffer full -> immediately BS_IDLE=1, in_ready=0 deasserted to 1, hasUnusedData=0; a later core_done is ignored.

Source files
------------

// File: rtl/bs_worker_port.sv
// bs_worker_port: one worker slot between an option-record feed, a pricing core
// and a result sink, sequenced by an external controller.
//
// Ports
//   clock, reset            single rising-edge clock, asynchronous active-low reset
//   in_valid/in_data/in_ready  record feed into a one-entry input buffer
//   BS_START, SERVE_REG     controller launch request and output grant
//   BS_READY, BS_DONE, BS_IDLE, hasUnusedData  status back to the controller
//   core_start/core_data    one-cycle launch pulse and record to the pricing core
//   core_done/core_result   one-cycle completion pulse and result from the core
//   out_valid/out_data/out_ready  held result towards the sink
//   job_count               served jobs, wraps modulo 2^CNT_W
//   proto_err               sticky protocol-violation flag
//
// Every output comes straight from a flop; status flops are loaded from the
// next-state values so they always agree with the state they describe.
module bs_worker_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RES_W  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              BS_START,
  input  logic              SERVE_REG,
  output logic              BS_READY,
  output logic              BS_DONE,
  output logic              BS_IDLE,
  output logic              hasUnusedData,
  output logic              core_start,
  output logic [DATA_W-1:0] core_data,
  input  logic              core_done,
  input  logic [RES_W-1:0]  core_result,
  output logic              out_valid,
  output logic [RES_W-1:0]  out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  job_count,
  output logic              proto_err
);

  typedef enum logic [1:0] {StIdle, StCompute, StDone, StServe} state_e;

  state_e              state_q, state_d;
  logic                full_q, full_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [DATA_W-1:0]   core_data_q, core_data_d;
  logic                core_start_q, core_start_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                in_ready_q, bs_ready_q, bs_done_q, bs_idle_q, out_valid_q;

  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    buf_d        = buf_q;
    core_data_d  = core_data_q;
    core_start_d = 1'b0;
    res_d        = res_q;
    cnt_d        = cnt_q;
    err_d        = err_q;

    // Buffer refills independently of the job FSM; no bypass into a same-cycle launch.
    if (in_valid && in_ready_q) begin
      buf_d  = in_data;
      full_d = 1'b1;
    end

    if (BS_START && !bs_ready_q) begin
      err_d = 1'b1;
    end
    if (core_done && (state_q != StCompute)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (BS_START && bs_ready_q) begin
          state_d      = StCompute;
          core_start_d = 1'b1;
          core_data_d  = buf_q;
          full_d       = 1'b0;
        end
      end
      StCompute: begin
        if (core_done) begin
          res_d   = core_result;
          state_d = StDone;
        end
      end
      StDone: begin
        if (SERVE_REG) begin
          state_d = StServe;
        end
      end
      StServe: begin
        // out_valid_q is 1 throughout StServe, so out_ready alone completes the handshake.
        if (out_ready) begin
          state_d = StIdle;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      full_q       <= 1'b0;
      buf_q        <= '0;
      core_data_q  <= '0;
      core_start_q <= 1'b0;
      res_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      bs_ready_q   <= 1'b0;
      bs_done_q    <= 1'b0;
      bs_idle_q    <= 1'b1;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      buf_q        <= buf_d;
      core_data_q  <= core_data_d;
      core_start_q <= core_start_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      in_ready_q   <= !full_d;
      bs_ready_q   <= (state_d == StIdle) && full_d;
      bs_done_q    <= (state_d == StDone) || (state_d == StServe);
      bs_idle_q    <= (state_d == StIdle);
      out_valid_q  <= (state_d == StServe);
    end
  end

  assign in_ready      = in_ready_q;
  assign BS_READY      = bs_ready_q;
  assign BS_DONE       = bs_done_q;
  assign BS_IDLE       = bs_idle_q;
  assign hasUnusedData = full_q;
  assign core_start    = core_start_q;
  assign core_data     = core_data_q;
  assign out_valid     = out_valid_q;
  assign out_data      = res_q;
  assign job_count     = cnt_q;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_bs_worker_port.sv
// Bench for bs_worker_port: directed protocol scenarios followed by a randomized
// phase. Expected results are queued when stimulus is issued; a negedge monitor
// pops and compares on every output handshake. A second instance with a 4-bit
// counter shares all inputs so counter wrap is reached in a short run.
module tb_bs_worker_port;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 32;
  localparam int unsigned CW = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, BS_START = 1'b0, SERVE_REG = 1'b0;
  logic core_done = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [RW-1:0] core_result = '0;
  logic in_ready, BS_READY, BS_DONE, BS_IDLE, hasUnusedData, core_start, out_valid;
  logic proto_err;
  logic [DW-1:0] core_data;
  logic [RW-1:0] out_data;
  logic [CW-1:0] job_count;
  // Wrap instance outputs
  logic w_in_ready, w_bs_ready, w_bs_done, w_bs_idle, w_unused, w_core_start, w_out_valid;
  logic w_proto_err;
  logic [DW-1:0] w_core_data;
  logic [RW-1:0] w_out_data;
  logic [3:0] job_count_w;

  bs_worker_port #(.DATA_W(DW), .RES_W(RW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .BS_START(BS_START), .SERVE_REG(SERVE_REG),
    .BS_READY(BS_READY), .BS_DONE(BS_DONE), .BS_IDLE(BS_IDLE),
    .hasUnusedData(hasUnusedData), .core_start(core_start), .core_data(core_data),
    .core_done(core_done), .core_result(core_result), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .job_count(job_count),
    .proto_err(proto_err)
  );

  bs_worker_port #(.DATA_W(DW), .RES_W(RW), .CNT_W(4)) dut_w (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(w_in_ready), .BS_START(BS_START), .SERVE_REG(SERVE_REG),
    .BS_READY(w_bs_ready), .BS_DONE(w_bs_done), .BS_IDLE(w_bs_idle),
    .hasUnusedData(w_unused), .core_start(w_core_start), .core_data(w_core_data),
    .core_done(core_done), .core_result(core_result), .out_valid(w_out_valid),
    .out_data(w_out_data), .out_ready(out_ready), .job_count(job_count_w),
    .proto_err(w_proto_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  int unsigned ref_jobs = 0;
  bit cnt_pend = 1'b0;
  logic [RW-1:0] last_res = '0;

  // Pricing-core stand-in used by the random phase
  bit core_pend = 1'b0;
  int core_lat = 0;
  logic [DW-1:0] core_hold = '0;

  function automatic logic [RW-1:0] price(input logic [DW-1:0] x);
    return {x[15:0], x[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every output handshake pops one expected result; the served-job
  // counter is compared on the following negedge, after it has updated.
  always @(negedge clock) begin
    if (cnt_pend) begin
      chk("job_count", 64'(job_count), 64'(ref_jobs % 65536));
      chk("job_count_wrap", 64'(job_count_w), 64'(ref_jobs % 16));
      cnt_pend = 1'b0;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", out_data);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e));
        last_res = e;
      end
      ref_jobs++;
      cnt_pend = 1'b1;
    end
  end

  // Full directed job from IDLE; load=0 means the record is already buffered.
  task automatic job(input bit load, input logic [DW-1:0] rec, input logic [RW-1:0] res);
    if (load) begin
      in_valid = 1'b1; in_data = rec;
      tick();
      in_valid = 1'b0;
    end
    chk("job_unused", 64'(hasUnusedData), 64'd1);
    chk("job_ready", 64'(BS_READY), 64'd1);
    BS_START = 1'b1;
    tick();
    BS_START = 1'b0;
    chk("job_core_start", 64'(core_start), 64'd1);
    chk("job_core_data", 64'(core_data), 64'(rec));
    chk("job_unused_cleared", 64'(hasUnusedData), 64'd0);
    chk("job_idle_low", 64'(BS_IDLE), 64'd0);
    core_done = 1'b1; core_result = res; exp_q.push_back(res);
    tick();
    core_done = 1'b0;
    chk("job_start_pulse_end", 64'(core_start), 64'd0);
    chk("job_bs_done", 64'(BS_DONE), 64'd1);
    SERVE_REG = 1'b1;
    tick();
    SERVE_REG = 1'b0;
    chk("job_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("job_idle", 64'(BS_IDLE), 64'd1);
    chk("job_out_valid_low", 64'(out_valid), 64'd0);
    chk("job_done_low", 64'(BS_DONE), 64'd0);
  endtask

  task automatic drive_core();
    core_done = 1'b0;
    if (core_start) begin
      core_pend = 1'b1;
      core_lat  = $urandom_range(0, 3);
      core_hold = core_data;
    end
    if (core_pend) begin
      if (core_lat == 0) begin
        core_done   = 1'b1;
        core_result = price(core_hold);
        core_pend   = 1'b0;
      end else begin
        core_lat--;
      end
    end
  endtask

  task automatic rand_cycle(input bit feed);
    tick();
    chk("inv_in_ready", 64'(in_ready), 64'(!hasUnusedData));
    chk("inv_bs_ready", 64'(BS_READY), 64'(BS_IDLE && hasUnusedData));
    drive_core();
    in_valid = feed && ($urandom_range(0, 2) != 0);
    in_data  = $urandom;
    if (in_valid && in_ready) exp_q.push_back(price(in_data));
    BS_START  = BS_READY && ($urandom_range(0, 1) == 1);
    SERVE_REG = BS_DONE && ($urandom_range(0, 1) == 1);
    out_ready = feed ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] held;
    // Reset values while reset is low, before any clock edge
    #1 reset = 1'b0;
    #2;
    chk("rst_idle", 64'(BS_IDLE), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ready", 64'(BS_READY), 64'd0);
    chk("rst_done", 64'(BS_DONE), 64'd0);
    chk("rst_unused", 64'(hasUnusedData), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_core_data", 64'(core_data), 64'd0);
    chk("rst_job_count", 64'(job_count), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    #9 reset = 1'b1;
    tick();

    // Basic job
    job(1'b1, 32'h0000_1234, 32'hCAFE_0001);
    chk("basic_out_data", 64'(out_data), 64'hCAFE_0001);
    chk("basic_job_count", 64'(job_count), 64'd1);

    // Overlap: second record buffered while computing the first
    in_valid = 1'b1; in_data = 32'h0000_AAAA;
    tick();
    in_valid = 1'b0;
    BS_START = 1'b1;
    tick();
    BS_START = 1'b0;
    chk("ovl_core_data", 64'(core_data), 64'h0000_AAAA);
    chk("ovl_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = 32'h0000_BBBB;
    tick();
    in_valid = 1'b0;
    chk("ovl_unused_c", 64'(hasUnusedData), 64'd1);
    chk("ovl_ready_c", 64'(BS_READY), 64'd0);
    core_done = 1'b1; core_result = 32'h1111_0001; exp_q.push_back(32'h1111_0001);
    tick();
    core_done = 1'b0;
    chk("ovl_unused_d", 64'(hasUnusedData), 64'd1);
    chk("ovl_ready_d", 64'(BS_READY), 64'd0);
    SERVE_REG = 1'b1;
    tick();
    SERVE_REG = 1'b0;
    chk("ovl_ready_s", 64'(BS_READY), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ovl_ready_after", 64'(BS_READY), 64'd1);
    chk("ovl_idle_after", 64'(BS_IDLE), 64'd1);
    job(1'b0, 32'h0000_BBBB, 32'h2222_0002);

    // SERVE_REG outside DONE does nothing and raises no error
    SERVE_REG = 1'b1;
    tick();
    SERVE_REG = 1'b0;
    chk("serve_idle_err", 64'(proto_err), 64'd0);
    chk("serve_idle_valid", 64'(out_valid), 64'd0);
    chk("serve_idle_idle", 64'(BS_IDLE), 64'd1);

    // Protocol errors
    BS_START = 1'b1;
    tick();
    BS_START = 1'b0;
    chk("perr_no_start", 64'(core_start), 64'd0);
    chk("perr_set", 64'(proto_err), 64'd1);
    chk("perr_idle", 64'(BS_IDLE), 64'd1);
    core_done = 1'b1; core_result = 32'hDEAD_BEEF;
    tick();
    core_done = 1'b0;
    chk("perr_sticky", 64'(proto_err), 64'd1);
    chk("perr_out_data", 64'(out_data), 64'(last_res));
    chk("perr_no_done", 64'(BS_DONE), 64'd0);

    // Backpressure in SERVE
    in_valid = 1'b1; in_data = 32'h0000_5555;
    tick();
    in_valid = 1'b0;
    BS_START = 1'b1;
    tick();
    BS_START = 1'b0;
    held = 32'h3333_0003;
    core_done = 1'b1; core_result = held; exp_q.push_back(held);
    tick();
    core_done = 1'b0;
    SERVE_REG = 1'b1;
    tick();
    SERVE_REG = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", 64'(out_data), 64'(held));
      chk("bp_done", 64'(BS_DONE), 64'd1);
      chk("bp_count", 64'(job_count), 64'(ref_jobs % 65536));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_released", 64'(out_valid), 64'd0);

    // Randomized traffic, then drain
    for (int i = 0; i < 600; i++) rand_cycle(1'b1);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && BS_IDLE && !core_pend && !hasUnusedData) break;
      rand_cycle(1'b0);
    end
    in_valid = 1'b0; BS_START = 1'b0; SERVE_REG = 1'b0; core_done = 1'b0; out_ready = 1'b0;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_idle", 64'(BS_IDLE), 64'd1);
    tick();
    chk("final_job_count", 64'(job_count), 64'(ref_jobs % 65536));
    chk("final_job_count_wrap", 64'(job_count_w), 64'(ref_jobs % 16));

    // Reset mid-job: in COMPUTE with the buffer full
    in_valid = 1'b1; in_data = 32'h0000_7777;
    tick();
    in_valid = 1'b0;
    BS_START = 1'b1;
    tick();
    BS_START = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_8888;
    tick();
    in_valid = 1'b0;
    chk("mid_in_ready_before", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("mid_idle", 64'(BS_IDLE), 64'd1);
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    chk("mid_unused", 64'(hasUnusedData), 64'd0);
    chk("mid_job_count", 64'(job_count), 64'd0);
    chk("mid_proto_err", 64'(proto_err), 64'd0);
    exp_q.delete();
    ref_jobs = 0;
    last_res = '0;
    @(negedge clock);
    in_valid = 1'b1; in_data = 32'h0000_9999;
    #1 reset = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_accept", 64'(hasUnusedData), 64'd1);
    chk("post_rst_no_start", 64'(core_start), 64'd0);
    core_done = 1'b1; core_result = 32'hBAD0_BAD0;
    tick();
    core_done = 1'b0;
    chk("post_rst_done_ignored", 64'(BS_DONE), 64'd0);
    chk("post_rst_out_data", 64'(out_data), 64'd0);
    chk("post_rst_err", 64'(proto_err), 64'd1);
    job(1'b0, 32'h0000_9999, 32'h4444_0004);
    chk("post_rst_count", 64'(job_count), 64'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
